mem_resp_stage: RTL
===================

# mem_resp_stage

Parametrised memory-response pipeline stage between EXE and WB of the in-order core. It supports split-transaction data SRAM (request accepted in EXE, `data_ok` returning any number of cycles later), 32- or 64-bit datapaths and extended load types. It holds the instruction until its response arrives and buffers the loaded data while WB stalls. Under `MEM_FLUSH_EN` it discards cancelled in-flight responses after an exception flush.

## Interface
- `DW`, 32: datapath width; legal values are 32 and 64.
- `CNT_W`, 2: cancel-counter width; the counter saturates at 2^CNT_W-1.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `ex_mem_valid` in 1: EXE presents an instruction.
- `mem_allowin` out 1: stage can accept an instruction this cycle.
- `ex_mem_pc` in 32: PC of the instruction.
- `ex_mem_gr_we` in 1: instruction writes the register file.
- `ex_mem_dest` in 5: destination register.
- `ex_mem_alu_result` in DW: ALU result or effective address.
- `ex_mem_req` in 1: a data SRAM request was accepted (`addr_ok`) for this instruction.
- `ex_mem_load_op` in 3: load type. 0=none/store, 1=B, 2=BU, 3=H, 4=HU, 5=W, 6=WU, 7=D. Codes 6 and 7 are legal only when DW=64.
- `ex_req_inflight` in 1: EXE holds an accepted request that has not yet moved to MEM.
- `data_sram_data_ok` in 1: a response is valid this cycle.
- `data_sram_rdata` in DW: response data.
- `flush` in 1: exception/ertn flush. Used only with `MEM_FLUSH_EN`.
- `wb_allowin` in 1: WB can accept.
- `mem_wb_valid` out 1: instruction offered to WB.
- `mem_wb_pc` out 32: PC.
- `mem_wb_gr_we` out 1: register write enable.
- `mem_wb_dest` out 5: destination register.
- `mem_wb_result` out DW: final result.
- `fwd_dest` out 5: bypass destination; 0 when the stage is invalid or `gr_we`=0.
- `fwd_result` out DW: equal to `mem_wb_result`.
- `fwd_busy` out 1: valid load whose data has not yet returned. ID must stall on a match with `fwd_dest`.

## Operation
- The payload register loads on `ex_mem_valid && mem_allowin`. `valid` loads `ex_mem_valid` whenever `mem_allowin`=1.
- FSM states:
  - IDLE (stage empty).
  - WAIT (valid, `ex_mem_req`=1, no response yet).
  - DONE (valid, response captured or no request).
- Transitions:
  - Accept with `req`=1 → WAIT; accept with `req`=0 → DONE.
  - WAIT with an attributable `data_ok` → DONE, capturing `rdata` into `rbuf`.
  - DONE with `wb_allowin` and no new accept → IDLE.
- `ready_go` = DONE, or (WAIT and attributable `data_ok` this cycle). On the second term, `rdata` passes through combinationally that cycle.
- `mem_allowin` = !valid || (ready_go && wb_allowin). `mem_wb_valid` = valid && ready_go.
- Load extract: shift `rdata` right by `addr[log2(DW/8)-1:0]`×8.
  - B/H/W sign-extend to DW. BU/HU/WU zero-extend.
  - D takes all 64 bits.
  - With DW=32, W needs no extension.
- Result selection: `mem_wb_result` = extracted data if `load_op`≠0 and `req`; otherwise `alu_result`. Stores pass `alu_result`.
- A `data_ok` is attributable only when `cancel_cnt`==0. When `cancel_cnt`>0, the response is consumed and `cancel_cnt` decrements.
- A `data_ok` in IDLE or DONE with `cancel_cnt`==0 is a protocol error. It is ignored and does not alter state.

## Timing
- Reset (asynchronous, immediate):
  - `valid`=0, FSM=IDLE, `cancel_cnt`=0.
  - Payload and `rbuf`=0; all outputs therefore 0.
  - `mem_allowin`=1.
- Reset asserted mid-WAIT drops the request. The bench must hold the SRAM in reset too.
- No-request instruction: 0 cycles in stage beyond the register stage (one cycle EXE→WB).
- Load: leaves the stage in the same cycle `data_ok` arrives if `wb_allowin`=1; otherwise it is held in DONE with `rbuf` stable.
- Back-to-back accepts are permitted: DONE + `wb_allowin` + new `ex_mem_valid` → new instruction loads the next cycle.
- The stage holds at most one request. Further outstanding requests belong to EXE.

## Configuration
- `MEM_FLUSH_EN` defined: `flush` forces `valid`→0 and FSM→IDLE next cycle. In the same edge, `cancel_cnt` += (WAIT && !data_ok_this_cycle) + `ex_req_inflight`.
  - A `data_ok` coinciding with `flush` belongs to the flushed instruction. If `cancel_cnt`>0 at that edge, it decrements that counter instead.
  - Increment and decrement in the same cycle net out. The counter saturates.
  - `flush` wins over accept.
- `MEM_FLUSH_EN` undefined: the `flush` and `ex_req_inflight` ports exist but are ignored, and `cancel_cnt` is constant 0.

## Test plan
- ALU op (`req`=0, `alu_result`=0x1234, dest=5), `wb_allowin`=1 → next cycle `mem_wb_valid`=1, result 0x1234, `fwd_dest`=5, `fwd_busy`=0.
- LD.B at addr ...01, `data_ok` after 3 cycles with `rdata`=0x0000_8000 → `fwd_busy`=1 for 3 cycles, then result 0xFFFF_FF80 in the `data_ok` cycle.
- LD.HU at addr ...2, `rdata`=0x8765_0000, `wb_allowin`=0 for 2 cycles after `data_ok` → result held at 0x0000_8765 until accepted; `mem_allowin`=0 meanwhile.
- DW=64, LD.W at addr ...4, `rdata`=0x8000_0000_0000_0000 → 0xFFFF_FFFF_8000_0000; LD.WU → 0x0000_0000_8000_0000.
- `MEM_FLUSH_EN`: flush while in WAIT with `ex_req_inflight`=1 → `cancel_cnt`=2. The next two `data_ok` pulses are dropped, and a following load receives only the third response.
- Reset asserted in WAIT → all outputs 0 immediately, `mem_allowin`=1.

Source files
------------

// File: rtl/mem_resp_stage_if.sv
// mem_resp_stage_if: EXE-side, SRAM-response, WB-side and bypass signals of the memory-response stage.
// Latency: none, wires only.
// Backpressure: carries mem_allowin (toward EXE) and wb_allowin (from WB).
interface mem_resp_stage_if #(
  parameter int DW = 32
);
  logic          ex_mem_valid;
  logic          mem_allowin;
  logic [31:0]   ex_mem_pc;
  logic          ex_mem_gr_we;
  logic [4:0]    ex_mem_dest;
  logic [DW-1:0] ex_mem_alu_result;
  logic          ex_mem_req;
  logic [2:0]    ex_mem_load_op;
  logic          ex_req_inflight;
  logic          data_sram_data_ok;
  logic [DW-1:0] data_sram_rdata;
  logic          flush;
  logic          wb_allowin;
  logic          mem_wb_valid;
  logic [31:0]   mem_wb_pc;
  logic          mem_wb_gr_we;
  logic [4:0]    mem_wb_dest;
  logic [DW-1:0] mem_wb_result;
  logic [4:0]    fwd_dest;
  logic [DW-1:0] fwd_result;
  logic          fwd_busy;

  // Environment side: EXE, data SRAM and WB drive the stage inputs.
  modport master (
    output ex_mem_valid, ex_mem_pc, ex_mem_gr_we, ex_mem_dest, ex_mem_alu_result,
           ex_mem_req, ex_mem_load_op, ex_req_inflight, data_sram_data_ok,
           data_sram_rdata, flush, wb_allowin,
    input  mem_allowin, mem_wb_valid, mem_wb_pc, mem_wb_gr_we, mem_wb_dest,
           mem_wb_result, fwd_dest, fwd_result, fwd_busy
  );

  // Stage side.
  modport slave (
    input  ex_mem_valid, ex_mem_pc, ex_mem_gr_we, ex_mem_dest, ex_mem_alu_result,
           ex_mem_req, ex_mem_load_op, ex_req_inflight, data_sram_data_ok,
           data_sram_rdata, flush, wb_allowin,
    output mem_allowin, mem_wb_valid, mem_wb_pc, mem_wb_gr_we, mem_wb_dest,
           mem_wb_result, fwd_dest, fwd_result, fwd_busy
  );
endinterface

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: EXE->WB memory stage holding one split-transaction load until data_ok; build option `MEM_FLUSH_EN adds flush and cancelled-response dropping.
// Latency: one register stage; a load leaves in the cycle its data_ok arrives (rdata passes through combinationally).
// Backpressure: mem_allowin low while waiting for data or while WB stalls; captured data is held stable in rbuf.
module mem_resp_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 2
) (
  input logic           clk,
  input logic           resetn,
  mem_resp_stage_if.slave bus
);

  localparam int OFF_W = $clog2(DW / 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               gr_we_q, gr_we_d;
  logic [4:0]         dest_q, dest_d;
  logic [DW-1:0]      alu_q, alu_d;
  logic               req_q, req_d;
  logic [2:0]         load_op_q, load_op_d;
  logic [DW-1:0]      rbuf_q, rbuf_d;
  logic [CNT_W-1:0]   cancel_cnt_q, cancel_cnt_d;

  logic               valid;
  logic               attrib_ok;
  logic               ready_go;
  logic               allowin;
  logic               accept;
  logic [DW-1:0]      src;
  logic [DW-1:0]      shifted;
  logic [DW-1:0]      ext;
  logic [DW-1:0]      result;

  // Handshake: a response only counts for this stage when no cancelled responses are still owed.
  assign valid     = (state_q != ST_IDLE);
  assign attrib_ok = bus.data_sram_data_ok && (cancel_cnt_q == '0);
  assign ready_go  = (state_q == ST_DONE) || ((state_q == ST_WAIT) && attrib_ok);
  assign allowin   = !valid || (ready_go && bus.wb_allowin);
  assign accept    = bus.ex_mem_valid && allowin;

  // Load extraction: live rdata in the arrival cycle, rbuf afterwards.
  always_comb begin
    src     = (state_q == ST_WAIT) ? bus.data_sram_rdata : rbuf_q;
    shifted = src >> {alu_q[OFF_W-1:0], 3'b000};
    case (load_op_q)
      3'd1:    ext = DW'($signed(shifted[7:0]));
      3'd2:    ext = DW'(shifted[7:0]);
      3'd3:    ext = DW'($signed(shifted[15:0]));
      3'd4:    ext = DW'(shifted[15:0]);
      3'd5:    ext = DW'($signed(shifted[31:0]));
      3'd6:    ext = DW'(shifted[31:0]);
      default: ext = shifted;
    endcase
    result = ((load_op_q != 3'd0) && req_q) ? ext : alu_q;
  end

  // Next-state: FSM transitions, payload capture, response buffering and cancel bookkeeping.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    gr_we_d      = gr_we_q;
    dest_d       = dest_q;
    alu_d        = alu_q;
    req_d        = req_q;
    load_op_d    = load_op_q;
    rbuf_d       = rbuf_q;
    cancel_cnt_d = cancel_cnt_q;

    if (accept) begin
      pc_d      = bus.ex_mem_pc;
      gr_we_d   = bus.ex_mem_gr_we;
      dest_d    = bus.ex_mem_dest;
      alu_d     = bus.ex_mem_alu_result;
      req_d     = bus.ex_mem_req;
      load_op_d = bus.ex_mem_load_op;
    end

    if (allowin) begin
      if (bus.ex_mem_valid) begin
        state_d = bus.ex_mem_req ? ST_WAIT : ST_DONE;
      end else begin
        state_d = ST_IDLE;
      end
    end else if ((state_q == ST_WAIT) && attrib_ok) begin
      state_d = ST_DONE;
    end

    if ((state_q == ST_WAIT) && attrib_ok) begin
      rbuf_d = bus.data_sram_rdata;
    end

`ifdef MEM_FLUSH_EN
    begin : cancel_logic
      logic [CNT_W+1:0] cnt_sum;
      logic             inc_wait;
      logic             inc_exe;
      logic             dec;
      inc_wait = bus.flush && (state_q == ST_WAIT) && !bus.data_sram_data_ok;
      inc_exe  = bus.flush && bus.ex_req_inflight;
      dec      = bus.data_sram_data_ok && (cancel_cnt_q != '0);
      cnt_sum  = (CNT_W+2)'(cancel_cnt_q) + (CNT_W+2)'(inc_wait)
               + (CNT_W+2)'(inc_exe) - (CNT_W+2)'(dec);
      if (cnt_sum > (CNT_W+2)'({CNT_W{1'b1}})) begin
        cancel_cnt_d = '1;
      end else begin
        cancel_cnt_d = cnt_sum[CNT_W-1:0];
      end
      // The flushed instruction is dropped even if something was accepted this cycle.
      if (bus.flush) begin
        state_d = ST_IDLE;
      end
    end
`else
    cancel_cnt_d = '0;
`endif
  end

`ifndef MEM_FLUSH_EN
  logic unused_flush_inputs;
  assign unused_flush_inputs = ^{bus.flush, bus.ex_req_inflight};
`endif

  // State and payload registers; reset empties the stage and drops any outstanding request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      gr_we_q      <= 1'b0;
      dest_q       <= '0;
      alu_q        <= '0;
      req_q        <= 1'b0;
      load_op_q    <= '0;
      rbuf_q       <= '0;
      cancel_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      gr_we_q      <= gr_we_d;
      dest_q       <= dest_d;
      alu_q        <= alu_d;
      req_q        <= req_d;
      load_op_q    <= load_op_d;
      rbuf_q       <= rbuf_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  assign bus.mem_allowin   = allowin;
  assign bus.mem_wb_valid  = valid && ready_go;
  assign bus.mem_wb_pc     = pc_q;
  assign bus.mem_wb_gr_we  = gr_we_q;
  assign bus.mem_wb_dest   = dest_q;
  assign bus.mem_wb_result = result;
  assign bus.fwd_dest      = (valid && gr_we_q) ? dest_q : 5'd0;
  assign bus.fwd_result    = result;
  assign bus.fwd_busy      = (state_q == ST_WAIT) && (load_op_q != 3'd0) && !attrib_ok;

endmodule
